// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM state
// encoding and the alignment check used when a request is classified.
package load_store_unit_pkg;

    // Access size codes carried on req_size.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_WRITE = 2'b10,
        S_RESP  = 2'b11
    } state_e;

    // True when the size code is reserved or the byte offset is not
    // naturally aligned for that size.
    function automatic logic size_or_align_error(input logic [1:0] size,
                                                 input logic [1:0] offset);
        logic err;
        err = 1'b0;
        case (size)
            SIZE_BYTE: err = 1'b0;
            SIZE_HALF: err = offset[0];
            SIZE_WORD: err = |offset;
            default:   err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational byte-lane steering for the load/store unit.
// Ports:
//   offset      in   byte offset within the word (addr[1:0])
//   size        in   access size code
//   is_unsigned in   loads: 1 = zero-extend, 0 = sign-extend
//   rdata       in   word read from memory
//   wdata       in   right-justified store data
//   load_data   out  extracted, extended load result
//   store_data  out  rdata with the addressed lane(s) replaced by wdata
module load_store_unit_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [4:0]  byte_lsb;
    logic [4:0]  half_lsb;

    always_comb begin
        // Little-endian lanes: byte k at [8k+7:8k], half h at [16h+15:16h].
        byte_lsb = {offset, 3'b000};
        half_lsb = {offset[1], 4'b0000};
        byte_sel = rdata[byte_lsb +: 8];
        half_sel = rdata[half_lsb +: 16];

        load_data = rdata;
        case (size)
            SIZE_BYTE: load_data = is_unsigned ? {24'h0, byte_sel}
                                               : {{24{byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_data = is_unsigned ? {16'h0, half_sel}
                                               : {{16{half_sel[15]}}, half_sel};
            default:   load_data = rdata;
        endcase

        store_data = rdata;
        case (size)
            SIZE_BYTE: store_data[byte_lsb +: 8]  = wdata[7:0];
            SIZE_HALF: store_data[half_lsb +: 16] = wdata[15:0];
            default:   store_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the word-wide data memory port.
// Byte/half stores are read-modify-write since the memory only has a word
// write enable. One request in flight at a time.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_write/size/unsigned     request attributes
//   req_address/req_wdata       byte address and right-justified store data
//   resp_valid/rdata/error      one-cycle completion, held load data, error flag
//   mem_write_enable/address/   memory write strobe, word index, merged write
//   mem_write_data                word
//   mem_read_data               combinational read of mem_address
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADD_WIDTH  = 32,
    parameter int unsigned DEPTH      = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADD_WIDTH-1:0]  req_address,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic                  mem_write_enable,
    output logic [ADD_WIDTH-1:0]  mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [1:0]            offset_q, offset_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_error_q, resp_error_d;
    logic [ADD_WIDTH-1:0]  mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_write_data_q, mem_write_data_d;

    logic [ADD_WIDTH-1:0]  word_idx;
    logic                  req_err;
    logic [DATA_WIDTH-1:0] load_word;
    logic [DATA_WIDTH-1:0] store_word;

    assign word_idx = {2'b00, req_address[ADD_WIDTH-1:2]};
    assign req_err  = size_or_align_error(req_size, req_address[1:0])
                    || (word_idx >= ADD_WIDTH'(DEPTH));

    // Steering works on the live read data, so the READ cycle's word lands
    // directly in the load result or the merged write word.
    load_store_unit_lane_align u_lane_align (
        .offset      (offset_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .rdata       (mem_read_data),
        .wdata       (wdata_q),
        .load_data   (load_word),
        .store_data  (store_word)
    );

    always_comb begin
        state_d          = state_q;
        write_d          = write_q;
        size_d           = size_q;
        unsigned_d       = unsigned_q;
        offset_d         = offset_q;
        wdata_d          = wdata_q;
        resp_rdata_d     = resp_rdata_q;
        resp_error_d     = resp_error_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d       = req_write;
                    size_d        = req_size;
                    unsigned_d    = req_unsigned;
                    offset_d      = req_address[1:0];
                    wdata_d       = req_wdata;
                    mem_address_d = word_idx;
                    resp_error_d  = req_err;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (req_write && (req_size == SIZE_WORD)) begin
                        // Full-word store needs no read; write the data as-is.
                        mem_write_data_d = req_wdata;
                        state_d          = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (write_q) begin
                    mem_write_data_d = store_word;
                    state_d          = S_WRITE;
                end else begin
                    resp_rdata_d = load_word;
                    state_d      = S_RESP;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            write_q          <= 1'b0;
            size_q           <= SIZE_BYTE;
            unsigned_q       <= 1'b0;
            offset_q         <= 2'b00;
            wdata_q          <= '0;
            resp_rdata_q     <= '0;
            resp_error_q     <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            write_q          <= write_d;
            size_q           <= size_d;
            unsigned_q       <= unsigned_d;
            offset_q         <= offset_d;
            wdata_q          <= wdata_d;
            resp_rdata_q     <= resp_rdata_d;
            resp_error_q     <= resp_error_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    assign req_ready        = (state_q == S_IDLE);
    assign resp_valid       = (state_q == S_RESP);
    assign resp_rdata       = resp_rdata_q;
    assign resp_error       = resp_error_q;
    // Reset gates the strobe so a write in flight is dropped immediately.
    assign mem_write_enable = (state_q == S_WRITE) && !reset;
    assign mem_address      = mem_address_q;
    assign mem_write_data   = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [128];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .DATA_WIDTH (32),
        .ADD_WIDTH  (32),
        .DEPTH      (128)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_address      (req_address),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    // Data memory model: combinational read, write on posedge.
    assign mem_read_data = (mem_address < 32'd128) ? mem[mem_address[6:0]] : 32'h0;
    always @(posedge clk) begin
        if (mem_write_enable && (mem_address < 32'd128)) mem[mem_address[6:0]] <= mem_write_data;
    end

    // Drive one request and observe it; lat = cycles after acceptance edge
    // until resp_valid (-1 if it never came).
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic err, output int wr_cnt,
                         output int wr_cycle, output logic [31:0] wr_addr,
                         output logic [31:0] wr_data);
        lat = -1; err = 1'b0; wr_cnt = 0; wr_cycle = -1; wr_addr = '0; wr_data = '0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_address = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (mem_write_enable) begin
                wr_cnt++; wr_cycle = k; wr_addr = mem_address; wr_data = mem_write_data;
            end
            if (resp_valid) begin
                lat = k; err = resp_error;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL reset_mwe got=%b exp=0", mem_write_enable); end
        checks++; if (mem_address !== 32'h0) begin failures++; $display("FAIL reset_maddr got=%h exp=0", mem_address); end
        checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    endtask

    task automatic test_word();
        int lat, wc, wcy; logic err; logic [31:0] wa, wd;
        issue(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, lat, err, wc, wcy, wa, wd);
        checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        checks++; if (wc !== 1 || wcy !== 1) begin failures++; $display("FAIL sw_write_pulse got=%0d@%0d exp=1@1", wc, wcy); end
        checks++; if (wa !== 32'h10) begin failures++; $display("FAIL sw_maddr got=%h exp=10", wa); end
        checks++; if (wd !== 32'hDEADBEEF || err !== 1'b0) begin failures++; $display("FAIL sw_wdata got=%h err=%b exp=deadbeef err=0", wd, err); end
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, err, wc, wcy, wa, wd);
        checks++; if (lat !== 2 || wc !== 0) begin failures++; $display("FAIL lw_latency got=%0d writes=%0d exp=2 writes=0", lat, wc); end
        checks++; if (resp_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", resp_rdata); end
    endtask

    task automatic test_byte();
        int lat, wc, wcy; logic err; logic [31:0] wa, wd;
        logic [31:0] addrs [3];
        logic        unss  [3];
        logic [31:0] exps  [3];
        addrs = '{32'h41, 32'h43, 32'h43};
        unss  = '{1'b0, 1'b0, 1'b1};
        exps  = '{32'h0000005A, 32'hFFFFFFDE, 32'h000000DE};
        issue(1'b1, 2'b00, 1'b0, 32'h41, 32'h0000005A, lat, err, wc, wcy, wa, wd);
        checks++; if (lat !== 3 || wcy !== 2 || wc !== 1) begin failures++; $display("FAIL sb_timing got=lat%0d wr%0d@%0d exp=lat3 wr1@2", lat, wc, wcy); end
        checks++; if (wd !== 32'hDEAD5AEF) begin failures++; $display("FAIL sb_merge got=%h exp=dead5aef", wd); end
        checks++; if (mem[16] !== 32'hDEAD5AEF) begin failures++; $display("FAIL sb_mem got=%h exp=dead5aef", mem[16]); end
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 2'b00, unss[i], addrs[i], 32'h0, lat, err, wc, wcy, wa, wd);
            checks++; if (resp_rdata !== exps[i] || lat !== 2) begin failures++; $display("FAIL lb_%0d got=%h lat=%0d exp=%h lat=2", i, resp_rdata, lat, exps[i]); end
        end
    endtask

    task automatic test_half();
        int lat, wc, wcy; logic err; logic [31:0] wa, wd;
        logic [31:0] addrs [3];
        logic        unss  [3];
        logic [31:0] exps  [3];
        addrs = '{32'h40, 32'h40, 32'h42};
        unss  = '{1'b0, 1'b1, 1'b0};
        exps  = '{32'hFFFF8001, 32'h00008001, 32'hFFFFDEAD};
        issue(1'b1, 2'b01, 1'b0, 32'h40, 32'h00008001, lat, err, wc, wcy, wa, wd);
        checks++; if (lat !== 3 || wd !== 32'hDEAD8001) begin failures++; $display("FAIL sh_merge got=%h lat=%0d exp=dead8001 lat=3", wd, lat); end
        checks++; if (mem[16] !== 32'hDEAD8001) begin failures++; $display("FAIL sh_mem got=%h exp=dead8001", mem[16]); end
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 2'b01, unss[i], addrs[i], 32'h0, lat, err, wc, wcy, wa, wd);
            checks++; if (resp_rdata !== exps[i]) begin failures++; $display("FAIL lh_%0d got=%h exp=%h", i, resp_rdata, exps[i]); end
        end
    endtask

    task automatic test_errors();
        int lat, wc, wcy; logic err; logic [31:0] wa, wd;
        logic        ws [4];
        logic [1:0]  ss [4];
        logic [31:0] as [4];
        ws = '{1'b0, 1'b1, 1'b0, 1'b0};
        ss = '{2'b10, 2'b01, 2'b11, 2'b10};
        as = '{32'h42, 32'h41, 32'h40, 32'h200};
        for (int i = 0; i < 4; i++) begin
            issue(ws[i], ss[i], 1'b0, as[i], 32'h00001234, lat, err, wc, wcy, wa, wd);
            checks++; if (lat !== 1 || err !== 1'b1) begin failures++; $display("FAIL err_%0d got=lat%0d err%b exp=lat1 err1", i, lat, err); end
            checks++; if (wc !== 0 || mem[16] !== 32'hDEAD8001) begin failures++; $display("FAIL err_nowrite_%0d got=writes%0d mem=%h exp=writes0 mem=dead8001", i, wc, mem[16]); end
        end
        // Error loads must not disturb the held load result (last was LH @ 0x42).
        checks++; if (resp_rdata !== 32'hFFFFDEAD) begin failures++; $display("FAIL err_rdata_held got=%h exp=ffffdead", resp_rdata); end
    endtask

    task automatic test_reset_during_write();
        logic saw_we;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_address = 32'h40; req_wdata = 32'h000000FF;
        @(negedge clk);   // READ
        req_valid = 1'b0;
        @(negedge clk);   // WRITE
        saw_we = mem_write_enable;
        reset = 1'b1;
        #1;
        checks++; if (saw_we !== 1'b1 || mem_write_enable !== 1'b0) begin failures++; $display("FAIL rst_gate got=pre%b post%b exp=pre1 post0", saw_we, mem_write_enable); end
        @(negedge clk);
        reset = 1'b0;
        checks++; if (mem[16] !== 32'hDEAD8001) begin failures++; $display("FAIL rst_mem got=%h exp=dead8001", mem[16]); end
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL rst_idle got=ready%b resp%b exp=ready1 resp0", req_ready, resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", resp_rdata); end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        int resps = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_address = 32'h40; req_wdata = 32'h0;
        for (int k = 0; k < 9; k++) begin
            if (req_ready && req_valid) accepts++;
            if (resp_valid) resps++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++; if (resps !== 3 || accepts !== 3) begin failures++; $display("FAIL held_valid got=acc%0d resp%0d exp=acc3 resp3", accepts, resps); end
        checks++; if (resp_rdata !== 32'hDEAD8001) begin failures++; $display("FAIL held_rdata got=%h exp=dead8001", resp_rdata); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_address = 32'h0; req_wdata = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_reset_during_write();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
